goertzel_angle_gen: RTL and testbench

Parametrised per-bin phase generator for the Goertzel filter bank. On a start pulse it multiplies one angle coefficient by each of NF bin indices in signed fixed point, LANES bins per cycle through a registered multiplier stage. It writes one saturated angle per bin and raises a sticky done flag. It feeds the cosine/sine coefficient stage ahead of the Goertzel recursion cores and supports restart, configurable lane count and format, and per-bin overflow flags.

---
 rtl/goertzel_angle_gen.sv | 127 ++++++++++++
 tb/tb_goertzel_angle_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_angle_gen.sv
// Per-bin angle generator: angle[i] = sat(ang_coef * k[i]) in signed Q(DW-FRAC).FRAC.
// LANES bins are issued per cycle and pass through one registered multiplier stage.
module goertzel_angle_gen #(
    parameter int NF    = 11,
    parameter int DW    = 64,
    parameter int FRAC  = 44,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NF*DW-1:0] k_arr_i,
    input  logic [DW-1:0]    ang_coef_i,
    output logic             busy,
    output logic             done,
    output logic [NF*DW-1:0] angle_o,
    output logic [NF-1:0]    sat_o
);
    localparam int G   = (NF + LANES - 1) / LANES;
    localparam int CW  = $clog2(G + 1);
    localparam int KPW = G * LANES * DW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       grp_q;
    logic                vld_q;
    logic                busy_q;
    logic                done_q;
    logic [DW-1:0]       coef_q;
    logic [KPW-1:0]      kpad_q;
    logic [LANES*DW-1:0] res_q;
    logic [LANES-1:0]    ovf_q;

    logic [LANES*DW-1:0] grp_ops;
    logic [LANES*DW-1:0] res_d;
    logic [LANES-1:0]    ovf_d;

    // Bin indices are zero-padded to whole groups, so lanes past NF multiply zero.
    assign grp_ops = (LANES*DW)'(kpad_q >> (cnt_q * (LANES * DW)));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DW-1:0]          opb;
        logic [2*DW-1:0]        prod;
        logic signed [2*DW-1:0] shf;

        assign opb  = grp_ops[l*DW +: DW];
        assign prod = {{DW{coef_q[DW-1]}}, coef_q} * {{DW{opb[DW-1]}}, opb};
        assign shf  = $signed(prod) >>> FRAC;
        // Overflow when the shifted product no longer equals its own DW-bit sign extension.
        assign ovf_d[l] = (shf != {{DW{shf[DW-1]}}, shf[DW-1:0]});
        assign res_d[l*DW +: DW] = !ovf_d[l]      ? shf[DW-1:0] :
                                   shf[2*DW-1]    ? {1'b1, {(DW-1){1'b0}}} :
                                                    {1'b0, {(DW-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            grp_q   <= '0;
            vld_q   <= 1'b0;
            coef_q  <= '0;
            kpad_q  <= '0;
            res_q   <= '0;
            ovf_q   <= '0;
        end else if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            coef_q  <= ang_coef_i;
            kpad_q  <= KPW'(k_arr_i);
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                RUN: begin
                    res_q <= res_d;
                    ovf_q <= ovf_d;
                    grp_q <= cnt_q;
                    vld_q <= 1'b1;
                    if (cnt_q == CW'(G - 1)) begin
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < NF; i++) begin : g_bin
        localparam int GI = i / LANES;
        localparam int LI = i % LANES;
        logic [DW-1:0] ang_q;
        logic          s_q;

        // A start on the same edge discards the in-flight group of the aborted run.
        always_ff @(posedge clk) begin
            if (rst) begin
                ang_q <= '0;
                s_q   <= 1'b0;
            end else if (start) begin
                s_q <= 1'b0;
            end else if (vld_q && grp_q == CW'(GI)) begin
                ang_q <= res_q[LI*DW +: DW];
                s_q   <= ovf_q[LI];
            end
        end

        assign angle_o[i*DW +: DW] = ang_q;
        assign sat_o[i]            = s_q;
    end

    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_goertzel_angle_gen.sv
// Bench for goertzel_angle_gen: LANES=1 and LANES=4 instances share stimulus and are
// checked against a range-based saturating fixed-point reference.
module tb_goertzel_angle_gen;
    localparam int NF   = 11;
    localparam int DW   = 64;
    localparam int FRAC = 44;
    localparam int NV   = 11;

    logic             clk;
    logic             rst;
    logic             start;
    logic [NF*DW-1:0] k_arr;
    logic [DW-1:0]    ang_coef;
    logic             busy1, done1, busy4, done4;
    logic [NF*DW-1:0] ang1, ang4;
    logic [NF-1:0]    sat1, sat4;

    int total = 0;
    int bad   = 0;

    logic [63:0] kv    [NF];
    logic [63:0] cap_k [NF];
    logic [63:0] cap_coef;

    typedef struct {
        logic [63:0] coef;
        logic [63:0] k0;
        logic [63:0] kstep;
        int          bin;
        logic [63:0] exp_ang;
        logic        exp_sat;
    } vec_t;

    vec_t tbl [NV];

    goertzel_angle_gen #(.NF(NF), .DW(DW), .FRAC(FRAC), .LANES(1)) u_l1 (
        .clk(clk), .rst(rst), .start(start), .k_arr_i(k_arr), .ang_coef_i(ang_coef),
        .busy(busy1), .done(done1), .angle_o(ang1), .sat_o(sat1)
    );

    goertzel_angle_gen #(.NF(NF), .DW(DW), .FRAC(FRAC), .LANES(4)) u_l4 (
        .clk(clk), .rst(rst), .start(start), .k_arr_i(k_arr), .ang_coef_i(ang_coef),
        .busy(busy4), .done(done4), .angle_o(ang4), .sat_o(sat4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Real-valued product floored to the LSB grid, then clamped to the representable range.
    function automatic void model(input logic [63:0] c, input logic [63:0] k,
                                  output logic [63:0] a, output logic s);
        logic signed [127:0] p, q, mx, mn;
        p  = $signed({{64{c[63]}}, c}) * $signed({{64{k[63]}}, k});
        q  = p >>> FRAC;
        mx = 128'sh7FFF_FFFF_FFFF_FFFF;
        mn = -mx - 128'sd1;
        if (q > mx) begin
            a = 64'h7FFF_FFFF_FFFF_FFFF;
            s = 1'b1;
        end else if (q < mn) begin
            a = 64'h8000_0000_0000_0000;
            s = 1'b1;
        end else begin
            a = q[63:0];
            s = 1'b0;
        end
    endfunction

    task automatic scramble();
        ang_coef = {$urandom(), $urandom()};
        for (int i = 0; i < NF * 2; i++) k_arr[i*32 +: 32] = $urandom();
    endtask

    task automatic apply_start(input logic [63:0] c);
        cap_coef = c;
        ang_coef = c;
        for (int i = 0; i < NF; i++) begin
            cap_k[i]           = kv[i];
            k_arr[i*DW +: DW]  = kv[i];
        end
        start = 1'b1;
    endtask

    // Walks cycles 1..20 after a start, scrambling inputs and checking the busy/done profile.
    task automatic watch(output int d1, output int d4, output int perr);
        d1 = -1; d4 = -1; perr = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            scramble();
            if (done1 && d1 < 0) d1 = c;
            if (done4 && d4 < 0) d4 = c;
            if (busy1 !== (c <= 12)) perr++;
            if (done1 !== (c >= 13)) perr++;
            if (busy4 !== (c <= 4))  perr++;
            if (done4 !== (c >= 5))  perr++;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [63:0]   ea;
        logic          es;
        logic [NF-1:0] esat;
        esat = '0;
        for (int i = 0; i < NF; i++) begin
            model(cap_coef, cap_k[i], ea, es);
            esat[i] = es;
            chk($sformatf("%s_l1_ang%0d", tag, i), ang1[i*DW +: DW], ea);
            chk($sformatf("%s_l4_ang%0d", tag, i), ang4[i*DW +: DW], ea);
        end
        chk({tag, "_l1_sat"}, 64'(sat1), 64'(esat));
        chk({tag, "_l4_sat"}, 64'(sat4), 64'(esat));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy1"}, 64'(busy1), 64'd0);
        chk({tag, "_done1"}, 64'(done1), 64'd0);
        chk({tag, "_busy4"}, 64'(busy4), 64'd0);
        chk({tag, "_done4"}, 64'(done4), 64'd0);
        chk({tag, "_ang1_any"}, 64'(|ang1), 64'd0);
        chk({tag, "_ang4_any"}, 64'(|ang4), 64'd0);
        chk({tag, "_sat1"}, 64'(sat1), 64'd0);
        chk({tag, "_sat4"}, 64'(sat4), 64'd0);
    endtask

    initial begin
        int                d1, d4, pe, b;
        logic signed [63:0] rs;
        logic [63:0]       ea;
        logic              es;

        rst = 1'b1; start = 1'b0; ang_coef = '0; k_arr = '0;

        tbl[0] = '{64'h0000_0800_0000_0000, 64'h0, 64'h0000_1000_0000_0000, 5, 64'h0000_2800_0000_0000, 1'b0};
        tbl[1] = '{64'hFFFF_F000_0000_0000, 64'h0, 64'h0000_1000_0000_0000, 3, 64'hFFFF_D000_0000_0000, 1'b0};
        tbl[2] = '{64'h4000_0000_0000_0000, 64'h0000_8000_0000_0000, 64'h0000_1000_0000_0000, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
        tbl[3] = '{64'h4000_0000_0000_0000, 64'hFFFF_8000_0000_0000, 64'hFFFF_F000_0000_0000, 0, 64'h8000_0000_0000_0000, 1'b1};
        tbl[4] = '{64'hFFFF_F000_0000_0000, 64'h8000_0000_0000_0000, 64'h1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
        tbl[5] = '{64'h0000_1000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[6] = '{64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        for (int r = 7; r < NV; r++) begin
            rs = {$urandom(), $urandom()};
            tbl[r].coef = rs >>> $urandom_range(2, 40);
            rs = {$urandom(), $urandom()};
            tbl[r].k0 = rs >>> $urandom_range(2, 40);
            rs = {$urandom(), $urandom()};
            tbl[r].kstep = rs >>> $urandom_range(8, 48);
            tbl[r].bin = int'($urandom_range(0, NF - 1));
            model(tbl[r].coef, tbl[r].k0 + 64'(tbl[r].bin) * tbl[r].kstep, ea, es);
            tbl[r].exp_ang = ea;
            tbl[r].exp_sat = es;
        end

        repeat (2) @(negedge clk);
        chk_reset_state("init");
        rst = 1'b0;

        for (int r = 0; r < NV; r++) begin
            for (int i = 0; i < NF; i++) kv[i] = tbl[r].k0 + 64'(i) * tbl[r].kstep;
            apply_start(tbl[r].coef);
            watch(d1, d4, pe);
            chk($sformatf("v%0d_lat_l1", r), 64'(d1), 64'd13);
            chk($sformatf("v%0d_lat_l4", r), 64'(d4), 64'd5);
            chk($sformatf("v%0d_profile", r), 64'(pe), 64'd0);
            compare_all($sformatf("v%0d", r));
            b = tbl[r].bin;
            chk($sformatf("v%0d_tbl_l1_ang", r), ang1[b*DW +: DW], tbl[r].exp_ang);
            chk($sformatf("v%0d_tbl_l4_ang", r), ang4[b*DW +: DW], tbl[r].exp_ang);
            chk($sformatf("v%0d_tbl_l1_sat", r), 64'(sat1[b]), 64'(tbl[r].exp_sat));
            chk($sformatf("v%0d_tbl_l4_sat", r), 64'(sat4[b]), 64'(tbl[r].exp_sat));
        end

        // Restart in cycle 5 with coefficient 0.25.
        for (int i = 0; i < NF; i++) kv[i] = 64'(i) << 44;
        apply_start(64'h0000_0800_0000_0000);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            scramble();
        end
        chk("rs_pre_done1", 64'(done1), 64'd0);
        chk("rs_pre_done4", 64'(done4), 64'd1);
        apply_start(64'h0000_0400_0000_0000);
        watch(d1, d4, pe);
        chk("rs_lat_l1_abs", 64'(d1 + 5), 64'd18);
        chk("rs_lat_l4", 64'(d4), 64'd5);
        chk("rs_profile", 64'(pe), 64'd0);
        for (int i = 0; i < NF; i++) begin
            chk($sformatf("rs_l1_q42_%0d", i), ang1[i*DW +: DW], 64'(i) << 42);
            chk($sformatf("rs_l4_q42_%0d", i), ang4[i*DW +: DW], 64'(i) << 42);
        end
        compare_all("rs");

        // Reset asserted in cycle 6 of a run.
        for (int i = 0; i < NF; i++) kv[i] = 64'(i) << 44;
        apply_start(64'h0000_0800_0000_0000);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            scramble();
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("midrst");
        apply_start(64'h0000_0800_0000_0000);
        watch(d1, d4, pe);
        chk("post_rst_lat_l1", 64'(d1), 64'd13);
        chk("post_rst_lat_l4", 64'(d4), 64'd5);
        chk("post_rst_profile", 64'(pe), 64'd0);
        compare_all("post_rst");

        // start and rst together: reset wins and the block stays idle.
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk_reset_state("rst_start");
        repeat (3) @(negedge clk);
        chk("rst_start_idle_busy1", 64'(busy1), 64'd0);
        chk("rst_start_idle_busy4", 64'(busy4), 64'd0);
        chk("rst_start_idle_done1", 64'(done1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
